// File: rtl/pwm_pkg.sv
// Shared definitions for the drum-motor PWM stage: default sizing,
// controller states and the duty ramp helper.
package pwm_pkg;

   localparam int PERIOD_TICKS = 100;
   localparam int DUTY_W       = 7;
   localparam int RAMP_STEP    = 1;
   localparam int DEAD_PERIODS = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOP,
      DEAD
   } state_t;

   // Moves cur one ramp step toward goal, landing exactly on goal when closer than a step.
   function automatic int ramp_toward(input int cur, input int goal, input int step);
      if (cur < goal) begin
         return (goal - cur < step) ? goal : cur + step;
      end else if (cur > goal) begin
         return (cur - goal < step) ? goal : cur - step;
      end
      return cur;
   endfunction

endpackage

// File: rtl/pwm_motor_driver_tick_sync_edge.sv
// Brings the prescaled square wave into the sysclk domain and turns each
// rising edge into a one-cycle tick.
module tick_sync_edge (
   input  logic sysclk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_tick
);

   logic sync1;
   logic sync2;
   logic sync_prev;

   // Two-flop synchronizer followed by a registered rising-edge detect.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
         o_tick    <= 1'b0;
      end else begin
         sync1     <= i_async;
         sync2     <= sync1;
         sync_prev <= sync2;
         o_tick    <= sync2 & ~sync_prev;
      end
   end

endmodule

// File: rtl/pwm_motor_driver.sv
// Soft-ramped, direction-aware PWM pair for the drum-motor H-bridge.
// All command inputs are sampled only at the period boundary so the
// outputs never glitch mid-period; reversals go through ramp-down and
// dead time so both legs are never driven together.
module pwm_motor_driver #(
   parameter int PERIOD_TICKS = pwm_pkg::PERIOD_TICKS,
   parameter int DUTY_W       = pwm_pkg::DUTY_W,
   parameter int RAMP_STEP    = pwm_pkg::RAMP_STEP,
   parameter int DEAD_PERIODS = pwm_pkg::DEAD_PERIODS
) (
   input  logic              sysclk,
   input  logic              i_rst_n,
   input  logic              i_tick_clk,
   input  logic              i_en,
   input  logic [DUTY_W-1:0] i_duty,
   input  logic              i_dir,
   output logic              o_pwm_a,
   output logic              o_pwm_b,
   output logic [DUTY_W-1:0] o_cur_duty,
   output logic              o_busy,
   output logic              o_at_speed
);

   import pwm_pkg::*;

   localparam int CNT_W  = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
   localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_TICKS - 1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PERIOD_TICKS);

   logic              tick;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              boundary;
   state_t            state;
   logic              dir_lat;
   logic [DEAD_W-1:0] dead_cnt;
   logic [DUTY_W-1:0] cur_duty;
   logic [DUTY_W-1:0] tgt_now;
   logic [DUTY_W-1:0] tgt_lat;
   logic [DUTY_W-1:0] ramp_run;
   logic [DUTY_W-1:0] ramp_stop;
   logic [DUTY_W-1:0] bnd_duty;
   logic              pwm_on_nxt;

   tick_sync_edge u_tick (
      .sysclk  (sysclk),
      .i_rst_n (i_rst_n),
      .i_async (i_tick_clk),
      .o_tick  (tick)
   );

   // Next count, clamped target, ramp candidates and the PWM level for the coming tick.
   always_comb begin
      cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      boundary  = tick && (cnt == CNT_LAST);
      tgt_now   = !i_en ? '0 : ((i_duty > DUTY_MAX) ? DUTY_MAX : i_duty);
      ramp_run  = DUTY_W'(ramp_toward(int'(cur_duty), int'(tgt_now), RAMP_STEP));
      ramp_stop = DUTY_W'(ramp_toward(int'(cur_duty), 0, RAMP_STEP));
      case (state)
         RUN:     bnd_duty = ramp_run;
         STOP:    bnd_duty = ramp_stop;
         default: bnd_duty = '0;
      endcase
      if (boundary) begin
         pwm_on_nxt = (bnd_duty != '0);
      end else begin
         pwm_on_nxt = (int'(cnt_nxt) < int'(cur_duty)) && (state != DEAD);
      end
   end

   // Period counter, boundary-driven controller and registered bridge legs.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt      <= '0;
         state    <= IDLE;
         dir_lat  <= 1'b0;
         dead_cnt <= '0;
         cur_duty <= '0;
         tgt_lat  <= '0;
         o_pwm_a  <= 1'b0;
         o_pwm_b  <= 1'b0;
      end else if (tick) begin
         cnt     <= cnt_nxt;
         o_pwm_a <= pwm_on_nxt & ~dir_lat;
         o_pwm_b <= pwm_on_nxt & dir_lat;
         if (boundary) begin
            tgt_lat  <= tgt_now;
            cur_duty <= bnd_duty;
            case (state)
               IDLE: begin
                  if (tgt_now != '0) begin
                     dir_lat <= i_dir;
                     state   <= RUN;
                  end
               end
               RUN: begin
                  if (i_dir != dir_lat) begin
                     state <= STOP;
                  end else if ((tgt_now == '0) && (ramp_run == '0)) begin
                     state <= IDLE;
                  end
               end
               STOP: begin
                  if (ramp_stop == '0) begin
                     state    <= DEAD;
                     dead_cnt <= '0;
                  end
               end
               DEAD: begin
                  if (dead_cnt == DEAD_LAST) begin
                     state <= IDLE;
                  end else begin
                     dead_cnt <= dead_cnt + DEAD_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_cur_duty = cur_duty;
   assign o_busy     = (state != IDLE);
   assign o_at_speed = (state == RUN) && (cur_duty == tgt_lat);

endmodule
